wb_arbiter: RTL

Writeback arbiter and sequencer for the integer register file's single write port. It shares that port between two writeback sources: s0, the execute/ALU result, and s1, the load/memory result. Arbitration is round-robin, and the winning write is registered into a one-entry output stage that drives the register file. It also provides a bypass of that staged write to the two read ports, so readers never see a value that has been accepted but not yet committed.

---
 rtl/wb_arbiter.sv | 76 +++++++
 1 files changed

// File: rtl/wb_arbiter.sv
// wb_arbiter: round-robin writeback arbiter for the register file write port,
// with a one-entry registered output stage and a bypass of the staged write.
module wb_arbiter #(
    parameter int XLEN = 32,
    parameter int NUM_REGS = 32,
    parameter int CNT_W = 16,
    localparam int RW = $clog2(NUM_REGS)
) (
    input  logic            clk_i,
    input  logic            reset_n_i,
    input  logic            hold_i,
    input  logic            s0_valid_i,
    output logic            s0_ready_o,
    input  logic [RW-1:0]   s0_rd_i,
    input  logic [XLEN-1:0] s0_data_i,
    input  logic            s1_valid_i,
    output logic            s1_ready_o,
    input  logic [RW-1:0]   s1_rd_i,
    input  logic [XLEN-1:0] s1_data_i,
    output logic            wr_en_o,
    output logic [RW-1:0]   wr_rd_o,
    output logic [XLEN-1:0] wr_data_o,
    input  logic [RW-1:0]   rs1_addr_i,
    input  logic [RW-1:0]   rs2_addr_i,
    output logic            rs1_hit_o,
    output logic            rs2_hit_o,
    output logic [XLEN-1:0] rs1_fwd_o,
    output logic [XLEN-1:0] rs2_fwd_o,
    output logic [CNT_W-1:0] conflict_cnt_o
);
    logic c0, c1, g0, g1;
    logic last_q, last_d, wr_en_q, wr_en_d;
    logic [RW-1:0] wr_rd_q, wr_rd_d;
    logic [XLEN-1:0] wr_data_q, wr_data_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // last_q=1 means s1 was granted most recently, so s0 wins the next tie
    always_comb begin
        c0 = s0_valid_i && (s0_rd_i != '0);
        c1 = s1_valid_i && (s1_rd_i != '0);
        g0 = !hold_i && c0 && (!c1 || last_q);
        g1 = !hold_i && c1 && (!c0 || !last_q);
        s0_ready_o = reset_n_i && (g0 || (s0_valid_i && s0_rd_i == '0));
        s1_ready_o = reset_n_i && (g1 || (s1_valid_i && s1_rd_i == '0));
        wr_en_d = g0 || g1;
        wr_rd_d = g0 ? s0_rd_i : g1 ? s1_rd_i : wr_rd_q;
        wr_data_d = g0 ? s0_data_i : g1 ? s1_data_i : wr_data_q;
        last_d = g0 ? 1'b0 : g1 ? 1'b1 : last_q;
        cnt_d = (((c0 && !g0) || (c1 && !g1)) && (cnt_q != '1)) ? cnt_q + 1'b1 : cnt_q;
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            wr_en_q   <= 1'b0;
            wr_rd_q   <= '0;
            wr_data_q <= '0;
            last_q    <= 1'b1;
            cnt_q     <= '0;
        end else begin
            wr_en_q   <= wr_en_d;
            wr_rd_q   <= wr_rd_d;
            wr_data_q <= wr_data_d;
            last_q    <= last_d;
            cnt_q     <= cnt_d;
        end
    end

    assign wr_en_o = wr_en_q;
    assign wr_rd_o = wr_rd_q;
    assign wr_data_o = wr_data_q;
    assign conflict_cnt_o = cnt_q;
    assign rs1_hit_o = wr_en_q && (wr_rd_q == rs1_addr_i) && (rs1_addr_i != '0);
    assign rs2_hit_o = wr_en_q && (wr_rd_q == rs2_addr_i) && (rs2_addr_i != '0);
    assign rs1_fwd_o = rs1_hit_o ? wr_data_q : '0;
    assign rs2_fwd_o = rs2_hit_o ? wr_data_q : '0;
endmodule
